// File: rtl/iiitb_cg_pkg.sv
// Shared types for the clock-gate controller: channel FSM states and channel count.
package iiitb_cg_pkg;

    // Per-channel gating state: OFF (gated), WAKE (ICG enabled, clock settling),
    // ON (clock stable, ack high), IDLE (still enabled, counting down to OFF).
    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_IDLE = 2'd3
    } cg_state_t;

    localparam int NUM_CH = 2;

endpackage

// File: rtl/iiitb_cg_chan.sv
// One gated register group: OFF/WAKE/ON/IDLE FSM with saturating wake and idle
// counters and registered en/ack decodes. The current state is exported on
// `state` for the parent arbiter and for observation.
// Optional: IIITB_CG_STATS_EN adds gated_cnt, counting cycles with en low.
module iiitb_cg_chan
    import iiitb_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      req,
    input  logic      grant,
    input  logic      test_en,
    output logic      en,
    output logic      ack,
    output logic      wake_hold,
    output cg_state_t state
`ifdef IIITB_CG_STATS_EN
    ,
    output logic [CNT_W-1:0] gated_cnt
`endif
);

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);

    cg_state_t  state_nx;
    logic [3:0] wcnt, wcnt_nx;
    logic [7:0] icnt, icnt_nx;
    logic       en_r, ack_r;
    logic       wake_done;

    assign wake_done = (state == CG_WAKE) && (wcnt >= WAKE_LAST);
    // Still occupying the wake slot after this edge; the arbiter may hand the
    // slot to the other channel on the very edge this one leaves WAKE.
    assign wake_hold = (state == CG_WAKE) && !wake_done;

    // Next-state and counter logic; counters saturate instead of wrapping.
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        icnt_nx  = icnt;
        unique case (state)
            CG_OFF: begin
                if (req && grant) begin
                    state_nx = CG_WAKE;
                    wcnt_nx  = '0;
                end
            end
            CG_WAKE: begin
                // req is ignored here: a started wake always completes.
                if (wake_done)
                    state_nx = CG_ON;
                else if (wcnt != 4'hF)
                    wcnt_nx = wcnt + 4'd1;
            end
            CG_ON: begin
                if (!req) begin
                    state_nx = CG_IDLE;
                    icnt_nx  = '0;
                end
            end
            CG_IDLE: begin
                if (req)
                    state_nx = CG_ON;
                else if (icnt >= IDLE_LAST)
                    state_nx = CG_OFF;
                else if (icnt != 8'hFF)
                    icnt_nx = icnt + 8'd1;
            end
            default: state_nx = CG_OFF;
        endcase
    end

    // State, counters and registered output decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CG_OFF;
            wcnt  <= '0;
            icnt  <= '0;
            en_r  <= 1'b0;
            ack_r <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            icnt  <= icnt_nx;
            en_r  <= (state_nx != CG_OFF);
            ack_r <= (state_nx == CG_ON);
        end
    end

    // Scan override only touches the ICG enable, never the FSM.
    assign en  = en_r | test_en;
    assign ack = ack_r;

`ifdef IIITB_CG_STATS_EN
    // Count cycles during which this channel's clock is gated off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gated_cnt <= '0;
        else if (!en && (gated_cnt != {CNT_W{1'b1}}))
            gated_cnt <= gated_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// Two-channel clock-gate controller: per-channel FSMs plus a wake arbiter
// that lets only one channel be in WAKE at a time (inrush limit).
// Optional: IIITB_CG_STATS_EN exposes per-channel gated-cycle counters.
//
// Handshake: req[i] is a level request; the requester holds it high until
// ack[i] is seen. ack[i] high means the channel clock is stable and running.
// Dropping req after ack starts the idle countdown; raising it again before
// the countdown ends returns ack on the same edge without a new wake.
module iiitb_cg_ctrl
    import iiitb_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       test_en,
    output logic [1:0] en,
    output logic [1:0] ack,
    output logic       busy
`ifdef IIITB_CG_STATS_EN
    ,
    output logic [CNT_W-1:0] gated_cnt0,
    output logic [CNT_W-1:0] gated_cnt1
`endif
);

    logic [NUM_CH-1:0] want, hold, grant, in_wake;
    cg_state_t         ch_state [NUM_CH];
    logic              rr;
    logic              contend;
`ifdef IIITB_CG_STATS_EN
    logic [CNT_W-1:0]  gcnt [NUM_CH];
    assign gated_cnt0 = gcnt[0];
    assign gated_cnt1 = gcnt[1];
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        iiitb_cg_chan #(
            .IDLE_CYCLES(IDLE_CYCLES),
            .WAKE_CYCLES(WAKE_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .req      (req[i]),
            .grant    (grant[i]),
            .test_en  (test_en),
            .en       (en[i]),
            .ack      (ack[i]),
            .wake_hold(hold[i]),
            .state    (ch_state[i])
`ifdef IIITB_CG_STATS_EN
            ,
            .gated_cnt(gcnt[i])
`endif
        );
        assign want[i]    = req[i] && (ch_state[i] == CG_OFF);
        assign in_wake[i] = (ch_state[i] == CG_WAKE);
    end

    assign busy    = |in_wake;
    // Both channels asking from OFF on the same edge: the pointer decides.
    assign contend = want[0] & want[1];

    // Wake grant: blocked while the other channel keeps the wake slot;
    // on contention rr names the channel that wins.
    always_comb begin
        grant    = '0;
        grant[0] = want[0] & ~hold[1] & (~want[1] | ~rr);
        grant[1] = want[1] & ~hold[0] & (~want[0] |  rr);
    end

    // Round-robin pointer: after a contended grant it points at the loser.
    // Uncontended grants leave it alone so a waiting loser keeps priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr <= 1'b0;
        else if (contend)
            rr <= ~rr;
    end

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// Self-checking bench for iiitb_cg_ctrl with default parameters
// (IDLE_CYCLES=4, WAKE_CYCLES=2). Build with IIITB_CG_STATS_EN to also
// exercise the gated-cycle counters.
module tb_iiitb_cg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic       test_en = 1'b0;
    logic [1:0] en;
    logic [1:0] ack;
    logic       busy;
`ifdef IIITB_CG_STATS_EN
    logic [15:0] gated_cnt0;
    logic [15:0] gated_cnt1;
`endif

    iiitb_cg_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .test_en(test_en),
        .en     (en),
        .ack    (ack),
        .busy   (busy)
`ifdef IIITB_CG_STATS_EN
        ,
        .gated_cnt0(gated_cnt0),
        .gated_cnt1(gated_cnt1)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] req;
        logic       te;
        logic [1:0] en;
        logic [1:0] ack;
        logic       busy;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] r, input logic te, input logic [1:0] e,
                       input logic [1:0] a, input logic b);
        vec_t v;
        v.req  = r;
        v.te   = te;
        v.en   = e;
        v.ack  = a;
        v.busy = b;
        vecs.push_back(v);
    endtask

    // Each vector: drive inputs, push expectation, sample #1 after the edge.
    task automatic run_vecs(input string tag);
        logic [4:0] exp;
        for (int i = 0; i < vecs.size(); i++) begin
            req     = vecs[i].req;
            test_en = vecs[i].te;
            exp_q.push_back({vecs[i].en, vecs[i].ack, vecs[i].busy});
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            check($sformatf("%s_e%0d", tag, i + 1), {27'd0, en, ack, busy}, {27'd0, exp});
        end
        vecs.delete();
    endtask

    // Synchronous-looking reset pulse; ends at a negedge so the next posedge is edge 1.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        req     = 2'b00;
        test_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check("reset_state", {29'd0, en, ack, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Quiet channels stay gated.
        for (int i = 0; i < 20; i++) add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("quiet");

        // Single channel: wake, run, idle countdown, gate.
        do_reset();
        for (int i = 1; i <= 9; i++)
            add(2'b01, 1'b0, 2'b01, (i >= 3) ? 2'b01 : 2'b00, (i < 3) ? 1'b1 : 1'b0);
        for (int i = 10; i <= 13; i++) add(2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("single");

        // Simultaneous requests twice: ch0 first, then ch1 first.
        do_reset();
        add(2'b11, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b01, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b01, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 2'b11, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        add(2'b11, 1'b0, 2'b10, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b10, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b10, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b10, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 2'b11, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("rr");

        // Short req drop returns to ON without a new wake.
        do_reset();
        add(2'b01, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b01, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b01, 1'b0, 2'b01, 2'b01, 1'b0);
        add(2'b01, 1'b0, 2'b01, 2'b01, 1'b0);
        add(2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        add(2'b01, 1'b0, 2'b01, 2'b01, 1'b0);
        add(2'b01, 1'b0, 2'b01, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("rewake");

        // req dropped during WAKE: wake completes, ON for one edge, then IDLE.
        add(2'b01, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b00, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b00, 1'b0, 2'b01, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("wakedrop");

        // ch1 waits while ch0 occupies the wake slot.
        add(2'b01, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b01, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b01, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 2'b11, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("wait");

        // Scan override forces en only.
        for (int i = 0; i < 3; i++) add(2'b00, 1'b1, 2'b11, 2'b00, 1'b0);
        add(2'b10, 1'b1, 2'b11, 2'b00, 1'b1);
        add(2'b10, 1'b1, 2'b11, 2'b00, 1'b1);
        add(2'b10, 1'b0, 2'b10, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++) add(2'b00, 1'b1, 2'b11, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("test_en");

        // Asynchronous reset mid-WAKE, then full restart with pointer cleared.
        do_reset();
        add(2'b11, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b01, 2'b00, 1'b1);
        run_vecs("pre_rst");
        #2 rst = 1'b1;
        #1 check("async_rst", {29'd0, en, ack, busy}, 32'd0);
        @(posedge clk);
        #1 check("rst_hold", {29'd0, en, ack, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        add(2'b11, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b01, 2'b00, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b01, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b01, 1'b1);
        add(2'b11, 1'b0, 2'b11, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 2'b11, 2'b00, 1'b0);
        add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("post_rst");

`ifdef IIITB_CG_STATS_EN
        // Gated-cycle counters: count while en=0, hold while test_en forces en.
        do_reset();
        check("gcnt0_rst", {16'd0, gated_cnt0}, 32'd0);
        for (int i = 0; i < 5; i++) add(2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        run_vecs("stats_idle");
        check("gcnt0_idle", {16'd0, gated_cnt0}, 32'd5);
        check("gcnt1_idle", {16'd0, gated_cnt1}, 32'd5);
        for (int i = 0; i < 3; i++) add(2'b00, 1'b1, 2'b11, 2'b00, 1'b0);
        run_vecs("stats_te");
        check("gcnt0_te", {16'd0, gated_cnt0}, 32'd5);
        check("gcnt1_te", {16'd0, gated_cnt1}, 32'd5);
`endif

        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
